button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_debounce_channel.sv | 150 +++++++++++++++
 rtl/button_debouncer.sv | 34 +++
 tb/tb_button_debouncer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the button debouncer.
// Optional feature macro: BUTTON_LONG_PRESS_EN (long-press pulse output).
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES     = 50_000_000;

  // Counter width large enough to hold the larger of the two timing limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One debounced button channel: 2-flop synchronizer, four-state FSM,
// saturating counter and registered pulse outputs.
// Optional feature macro: BUTTON_LONG_PRESS_EN (long-press counting in PRESSED).
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`endif

  logic          r_sync1;
  logic          r_sync2;
  logic          w_sample;
  btn_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
`ifdef BUTTON_LONG_PRESS_EN
  logic          r_long;
  logic          r_long_done;
`endif

  assign w_sample = r_sync2;

  // Two-flop synchronizer bringing the asynchronous pad into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with its counter and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= CNT_ZERO;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
      r_long      <= 1'b0;
      r_long_done <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
      r_long    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_sample) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= CNT_ZERO;
          end
        end
        PRESS_WAIT: begin
          if (!w_sample) begin
            // Glitch: drop back without any pulse.
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_sample) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end else begin
`ifdef BUTTON_LONG_PRESS_EN
            // Count held cycles; saturate at the long-press threshold.
            if (r_cnt != LONG_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
            if ((r_cnt == LONG_LAST) && !r_long_done) begin
              r_long      <= 1'b1;
              r_long_done <= 1'b1;
            end
`else
            r_cnt <= CNT_ZERO;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (w_sample) begin
            // Release bounce: still pressed.
            r_state <= PRESSED;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_release <= 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
            r_long_done <= 1'b0;
`endif
          end else if (r_cnt != CNT_MAX) begin
            r_cnt     <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= CNT_ZERO;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
`ifdef BUTTON_LONG_PRESS_EN
  assign btn_long    = r_long;
`else
  assign btn_long    = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: NUM_BTN independent debounce channels.
// Optional feature macro: BUTTON_LONG_PRESS_EN (per-channel long-press pulse).
module button_debouncer
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_long   (btn_long[g])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (DEBOUNCE=8, LONG=32).
module tb_button_debouncer;

  localparam int NB = 4;
`ifdef BUTTON_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;

  int n_checks;
  int n_errors;
  int n_press   [NB];
  int n_release [NB];
  int n_long    [NB];
  int n_overlap;

  button_debouncer #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  initial begin
    n_overlap = 0;
    for (int i = 0; i < NB; i++) begin
      n_press[i] = 0; n_release[i] = 0; n_long[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NB; i++) begin
        if (btn_press[i])   n_press[i]++;
        if (btn_release[i]) n_release[i]++;
        if (btn_long[i])    n_long[i]++;
        if (btn_press[i] && btn_release[i]) n_overlap++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0, r0, p1, r1, r2, l2, p3, r3, l3;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_raw  = 4'b0000;
    tick(3);
    check_eq("rst_level",   32'(btn_level),   32'd0);
    check_eq("rst_press",   32'(btn_press),   32'd0);
    check_eq("rst_release", 32'(btn_release), 32'd0);
    check_eq("rst_long",    32'(btn_long),    32'd0);
    rst_n = 1'b1;
    tick(3);

    // Clean press and release on channel 0.
    p0 = n_press[0];
    btn_raw[0] = 1'b1;
    tick(9);
    check_eq("clean_pre_level", 32'(btn_level), 32'd0);
    tick(1);
    check_eq("clean_level", 32'(btn_level), 32'b0001);
    check_eq("clean_press", 32'(btn_press), 32'b0001);
    tick(1);
    check_eq("clean_press_1cyc", 32'(btn_press), 32'd0);
    check_eq("clean_press_cnt", 32'(n_press[0] - p0), 32'd1);
    btn_raw[0] = 1'b0;
    tick(10);
    check_eq("clean_release", 32'(btn_release), 32'b0001);
    check_eq("clean_rel_level", 32'(btn_level), 32'd0);
    tick(5);

    // Glitch rejection on channel 1.
    p1 = n_press[1]; r1 = n_release[1];
    btn_raw[1] = 1'b1;
    tick(5);
    btn_raw[1] = 1'b0;
    tick(20);
    check_eq("glitch_level",   32'(btn_level[1]), 32'd0);
    check_eq("glitch_press",   32'(n_press[1] - p1), 32'd0);
    check_eq("glitch_release", 32'(n_release[1] - r1), 32'd0);

    // Release with bounce on channel 2.
    btn_raw[2] = 1'b1;
    tick(15);
    check_eq("bounce_pressed", 32'(btn_level[2]), 32'd1);
    r2 = n_release[2]; l2 = n_long[2];
    btn_raw[2] = 1'b0; tick(3);
    btn_raw[2] = 1'b1; tick(3);
    btn_raw[2] = 1'b0; tick(3);
    btn_raw[2] = 1'b1; tick(3);
    btn_raw[2] = 1'b0;
    tick(9);
    check_eq("bounce_pre_rel", 32'(btn_release[2]), 32'd0);
    check_eq("bounce_pre_lvl", 32'(btn_level[2]), 32'd1);
    tick(1);
    check_eq("bounce_rel", 32'(btn_release[2]), 32'd1);
    check_eq("bounce_lvl", 32'(btn_level[2]), 32'd0);
    tick(10);
    check_eq("bounce_rel_cnt", 32'(n_release[2] - r2), 32'd1);
    check_eq("bounce_no_long", 32'(n_long[2] - l2), 32'd0);

    // Long press on channel 3.
    p3 = n_press[3]; r3 = n_release[3]; l3 = n_long[3];
    btn_raw[3] = 1'b1;
    tick(10);
    check_eq("long_press", 32'(btn_press[3]), 32'd1);
    tick(31);
    check_eq("long_pre", 32'(btn_long[3]), 32'd0);
    tick(1);
    check_eq("long_pulse", 32'(btn_long[3]), 32'(EXP_LONG));
    tick(18);
    btn_raw[3] = 1'b0;
    tick(15);
    check_eq("long_cnt",     32'(n_long[3] - l3),    32'(EXP_LONG));
    check_eq("long_press_n", 32'(n_press[3] - p3),   32'd1);
    check_eq("long_rel_n",   32'(n_release[3] - r3), 32'd1);

    // Reset while channel 0 is pressed.
    btn_raw[0] = 1'b1;
    tick(15);
    check_eq("rstmid_pressed", 32'(btn_level[0]), 32'd1);
    r0 = n_release[0];
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_level_now", 32'(btn_level), 32'd0);
    tick(3);
    check_eq("rstmid_level", 32'(btn_level), 32'd0);
    check_eq("rstmid_outs",  32'({btn_press, btn_release, btn_long}), 32'd0);
    rst_n = 1'b1;
    tick(9);
    check_eq("rstmid_pre_press", 32'(btn_press[0]), 32'd0);
    tick(1);
    check_eq("rstmid_repress", 32'(btn_press[0]), 32'd1);
    check_eq("rstmid_no_rel",  32'(n_release[0] - r0), 32'd0);
    btn_raw[0] = 1'b0;
    tick(15);

    // Simultaneous press and release on channels 0 and 3.
    btn_raw = 4'b1001;
    tick(10);
    check_eq("simul_press", 32'(btn_press), 32'b1001);
    tick(1);
    check_eq("simul_press_1cyc", 32'(btn_press), 32'd0);
    btn_raw = 4'b0000;
    tick(10);
    check_eq("simul_release", 32'(btn_release), 32'b1001);
    tick(5);
    check_eq("no_overlap", 32'(n_overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
